// File: rtl/uart_rx_fifo.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module      : uart_rx_fifo                                                  |
// | Description : 8N1 UART receiver feeding a small show-ahead byte FIFO with   |
// |               a valid/ready read port. Line is double-flop synchronised;    |
// |               all decisions use the synchronised level.                     |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
module uart_rx_fifo #(
    parameter int CLK_HZ     = 50_000_000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          rx_i,
    output logic [7:0]                    rd_data,
    output logic                          rd_valid,
    input  logic                          rd_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          frame_err,
    output logic                          overrun,
    input  logic                          clr_err
);

    localparam int c_CLKS_PER_BIT = (CLK_HZ + BAUD / 2) / BAUD;
    localparam int c_CNT_W        = $clog2(c_CLKS_PER_BIT);
    localparam int c_PTR_W        = $clog2(FIFO_DEPTH);

    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(c_CLKS_PER_BIT - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_HALF = c_CNT_W'(c_CLKS_PER_BIT / 2 - 1);
    localparam logic [c_PTR_W:0]   c_FULL     = FIFO_DEPTH[c_PTR_W:0];

    localparam logic [2:0] c_S_IDLE  = 3'd0;
    localparam logic [2:0] c_S_START = 3'd1;
    localparam logic [2:0] c_S_DATA  = 3'd2;
    localparam logic [2:0] c_S_STOP  = 3'd3;
    localparam logic [2:0] c_S_BREAK = 3'd4;

    logic               r_sync1;
    logic               r_sync2;
    logic [2:0]         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [2:0]         r_idx;
    logic [7:0]         r_shreg;
    logic               r_push;
    logic               r_frame_err;

    logic [7:0]         r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W:0]   r_count;
    logic               r_overrun;

    logic               w_rxs;
    logic               w_full;
    logic               w_pop;
    logic               w_wr;

    assign w_rxs  = r_sync2;
    assign w_full = (r_count == c_FULL);
    assign w_pop  = rd_valid && rd_ready;
    // A full FIFO still accepts a byte when the head leaves in the same cycle.
    assign w_wr   = r_push && (!w_full || w_pop);

    assign rd_data    = r_mem[r_rd_ptr];
    assign rd_valid   = (r_count != '0);
    assign fifo_count = r_count;
    assign frame_err  = r_frame_err;
    assign overrun    = r_overrun;

    // Two-flop synchroniser, preset to the idle-high line level.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rx_i;
            r_sync2 <= r_sync1;
        end
    end

    // Receive FSM: mid-bit sampling, byte assembly, push request and framing errors.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= c_S_IDLE;
            r_cnt       <= '0;
            r_idx       <= 3'd0;
            r_shreg     <= 8'h00;
            r_push      <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_push      <= 1'b0;
            r_frame_err <= 1'b0;
            case (r_state)
                c_S_IDLE: begin
                    if (!w_rxs) begin
                        r_state <= c_S_START;
                        r_cnt   <= '0;
                    end
                end
                c_S_START: begin
                    if (r_cnt == c_CNT_HALF) begin
                        r_cnt <= '0;
                        if (!w_rxs) begin
                            r_state <= c_S_DATA;
                            r_idx   <= 3'd0;
                        end else begin
                            // Start bit did not survive to mid-bit: treat as a glitch.
                            r_state <= c_S_IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
                end
                c_S_DATA: begin
                    if (r_cnt == c_CNT_LAST) begin
                        r_cnt   <= '0;
                        r_shreg <= {w_rxs, r_shreg[7:1]};
                        if (r_idx == 3'd7) begin
                            r_state <= c_S_STOP;
                        end else begin
                            r_idx <= r_idx + 3'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
                end
                c_S_STOP: begin
                    if (r_cnt == c_CNT_LAST) begin
                        r_cnt <= '0;
                        if (w_rxs) begin
                            r_push  <= 1'b1;
                            r_state <= c_S_IDLE;
                        end else begin
                            r_frame_err <= 1'b1;
                            r_state     <= c_S_BREAK;
                        end
                    end else begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
                end
                c_S_BREAK: begin
                    // Stay here until the line returns high so a held-low line yields one error only.
                    if (w_rxs) begin
                        r_state <= c_S_IDLE;
                    end
                end
                default: begin
                    r_state <= c_S_IDLE;
                end
            endcase
        end
    end

    // Show-ahead FIFO storage, pointers, occupancy and sticky overrun flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= 8'h00;
            end
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (w_wr) begin
                r_mem[r_wr_ptr] <= r_shreg;
                r_wr_ptr        <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + (c_PTR_W + 1)'(1);
                2'b01:   r_count <= r_count - (c_PTR_W + 1)'(1);
                default: r_count <= r_count;
            endcase
            // A fresh drop wins over a simultaneous clear.
            if (r_push && !w_wr) begin
                r_overrun <= 1'b1;
            end else if (clr_err) begin
                r_overrun <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
`timescale 1ns/1ps
// +-----------------------------------------------------------------------------+
// | Module      : tb_uart_rx_fifo                                               |
// | Description : Directed self-checking bench for uart_rx_fifo with a byte     |
// |               scoreboard queue.                                             |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
module tb_uart_rx_fifo;

    localparam int CLK_HZ = 1_600_000;
    localparam int BAUD   = 100_000;
    localparam int DEPTH  = 8;
    localparam int CPB    = (CLK_HZ + BAUD / 2) / BAUD;
    // Negedges from the start-bit drive to the cycle whose closing edge performs the push.
    localparam int PUSH_K = 3 + CPB / 2 + 9 * CPB;

    logic       clk      = 1'b0;
    logic       reset_n  = 1'b0;
    logic       rx_i     = 1'b1;
    logic       rd_ready = 1'b0;
    logic       clr_err  = 1'b0;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic [3:0] fifo_count;
    logic       frame_err;
    logic       overrun;

    int         checks    = 0;
    int         failures  = 0;
    int         fe_cycles = 0;
    int         fe0;
    logic [7:0] sb [$];

    always #5 clk = ~clk;

    uart_rx_fifo #(
        .CLK_HZ     (CLK_HZ),
        .BAUD       (BAUD),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .rx_i       (rx_i),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .rd_ready   (rd_ready),
        .fifo_count (fifo_count),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .clr_err    (clr_err)
    );

    // Count every cycle frame_err is high so pulse width is checked too.
    always @(negedge clk) if (frame_err) fe_cycles++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Drives one frame from a negedge; the stop level is left on the line.
    task automatic send_byte(input logic [7:0] b, input logic stop);
        rx_i = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_i = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx_i = stop;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic idle_bits(input int n);
        rx_i = 1'b1;
        repeat (n * CPB) @(negedge clk);
    endtask

    // Pops n bytes, comparing each head against the scoreboard.
    task automatic drain(input string tag, input int n);
        logic [31:0] exp;
        for (int k = 0; k < n; k++) begin
            int w = 0;
            while (!rd_valid && w < 4 * CPB) begin
                @(negedge clk);
                w++;
            end
            chk({tag, "_valid"}, {31'd0, rd_valid}, 32'd1);
            exp = (sb.size() > 0) ? {24'd0, sb.pop_front()} : 32'hDEAD;
            chk({tag, "_data"}, {24'd0, rd_data}, exp);
            rd_ready = 1'b1;
            @(negedge clk);
            rd_ready = 1'b0;
        end
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_data",  {24'd0, rd_data},    32'h00);
        chk("rst_valid", {31'd0, rd_valid},   32'd0);
        chk("rst_count", {28'd0, fifo_count}, 32'd0);
        chk("rst_ferr",  {31'd0, frame_err},  32'd0);
        chk("rst_ovr",   {31'd0, overrun},    32'd0);
        reset_n = 1'b1;
        idle_bits(1);

        // T1: single byte lands within the frame time
        sb.push_back(8'hA5);
        send_byte(8'hA5, 1'b1);
        chk("t1_valid", {31'd0, rd_valid},   32'd1);
        chk("t1_data",  {24'd0, rd_data},    32'hA5);
        chk("t1_count", {28'd0, fifo_count}, 32'd1);
        drain("t1", 1);
        chk("t1_empty", {28'd0, fifo_count}, 32'd0);

        // T2: short low glitch is rejected at the start-bit sample
        rx_i = 1'b0;
        repeat (3) @(negedge clk);
        idle_bits(3);
        chk("t2_ferr",  fe_cycles,           32'd0);
        chk("t2_count", {28'd0, fifo_count}, 32'd0);
        chk("t2_valid", {31'd0, rd_valid},   32'd0);

        // T3: bad stop bit with line held low, then recovery
        fe0 = fe_cycles;
        send_byte(8'h3C, 1'b0);
        repeat (2 * CPB) @(negedge clk);
        idle_bits(2);
        chk("t3_ferr",  fe_cycles - fe0,     32'd1);
        chk("t3_count", {28'd0, fifo_count}, 32'd0);
        sb.push_back(8'h55);
        send_byte(8'h55, 1'b1);
        idle_bits(1);
        drain("t3", 1);

        // T4: nine bytes into eight slots -> overrun, ninth dropped
        for (int b = 1; b <= 9; b++) begin
            if (b <= DEPTH) sb.push_back(8'(b));
            send_byte(8'(b), 1'b1);
        end
        idle_bits(1);
        chk("t4_count", {28'd0, fifo_count}, 32'd8);
        chk("t4_ovr",   {31'd0, overrun},    32'd1);
        drain("t4", 8);
        chk("t4_ovr_sticky", {31'd0, overrun}, 32'd1);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        chk("t4_ovr_clr",   {31'd0, overrun},    32'd0);
        chk("t4_empty",     {28'd0, fifo_count}, 32'd0);

        // T5: push and pop in the same cycle while full
        for (int b = 1; b <= 8; b++) begin
            sb.push_back(8'(b));
            send_byte(8'(b), 1'b1);
        end
        idle_bits(1);
        chk("t5_full", {28'd0, fifo_count}, 32'd8);
        fork
            send_byte(8'h09, 1'b1);
            begin
                repeat (PUSH_K) @(negedge clk);
                chk("t5_pre_count", {28'd0, fifo_count}, 32'd8);
                chk("t5_pre_head",  {24'd0, rd_data},    {24'd0, sb[0]});
                rd_ready = 1'b1;
                @(negedge clk);
                rd_ready = 1'b0;
                void'(sb.pop_front());
                sb.push_back(8'h09);
                chk("t5_count", {28'd0, fifo_count}, 32'd8);
                chk("t5_head",  {24'd0, rd_data},    32'h02);
                chk("t5_ovr",   {31'd0, overrun},    32'd0);
            end
        join
        idle_bits(1);
        drain("t5", 8);

        // T6: reset mid-frame flushes everything; reception resumes afterwards
        send_byte(8'h5A, 1'b1);
        idle_bits(1);
        chk("t6_pre_count", {28'd0, fifo_count}, 32'd1);
        fork
            send_byte(8'hF0, 1'b1);
            begin
                repeat (CPB / 2 + 3 * CPB) @(negedge clk);
                reset_n = 1'b0;
                @(negedge clk);
                chk("t6_rst_valid", {31'd0, rd_valid},   32'd0);
                chk("t6_rst_count", {28'd0, fifo_count}, 32'd0);
                chk("t6_rst_data",  {24'd0, rd_data},    32'h00);
                chk("t6_rst_ferr",  {31'd0, frame_err},  32'd0);
            end
        join
        sb.delete();
        reset_n = 1'b1;
        idle_bits(1);
        sb.push_back(8'h81);
        send_byte(8'h81, 1'b1);
        idle_bits(1);
        drain("t6", 1);
        chk("t6_empty", {28'd0, fifo_count}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
